// File: rtl/serial_out_dfreq_if.sv
// Control/data bundle for serial_out_dfreq.
// master: frame source (drives i_*), slave: the shifter (drives o_*).
// i_repeat_cnt exists only when SERIAL_OUT_RPT_CNT_EN is defined.
interface serial_out_dfreq_if #(
  parameter int DATA_BIT = 32,
  parameter int CNT_W    = 8,
  parameter int RPT_W    = 8
);
  localparam int LEN_W = $clog2(DATA_BIT + 1);

  logic                i_tick;
  logic                i_start;
  logic                i_stop;
  logic [1:0]          i_idle_mode;
  logic                i_msb_first;
  logic [LEN_W-1:0]    i_bit_len;
  logic [DATA_BIT-1:0] i_data;
  logic [DATA_BIT-1:0] i_freq_sel;
  logic [CNT_W-1:0]    i_period_h;
  logic [CNT_W-1:0]    i_period_l;
`ifdef SERIAL_OUT_RPT_CNT_EN
  logic [RPT_W-1:0]    i_repeat_cnt;
`endif
  logic                o_data;
  logic                o_busy;
  logic                o_bit_tick;
  logic                o_done_tick;

  modport master (
`ifdef SERIAL_OUT_RPT_CNT_EN
    output i_repeat_cnt,
`endif
    output i_tick, i_start, i_stop, i_idle_mode, i_msb_first, i_bit_len,
    output i_data, i_freq_sel, i_period_h, i_period_l,
    input  o_data, o_busy, o_bit_tick, o_done_tick
  );

  modport slave (
`ifdef SERIAL_OUT_RPT_CNT_EN
    input  i_repeat_cnt,
`endif
    input  i_tick, i_start, i_stop, i_idle_mode, i_msb_first, i_bit_len,
    input  i_data, i_freq_sel, i_period_h, i_period_l,
    output o_data, o_busy, o_bit_tick, o_done_tick
  );
endinterface

// File: rtl/serial_out_dfreq.sv
// serial_out_dfreq: dual-period serial bit-stream generator.
// Shifts out 1..DATA_BIT bits; each bit lasts max(1, period_h|period_l) i_tick pulses
// chosen per bit by i_freq_sel. MSB-first frames are bit-reversed at capture so the
// shifter always emits bit 0 and shifts right.
// Optional feature macro: SERIAL_OUT_RPT_CNT_EN (bounded REPEAT count via i_repeat_cnt).
module serial_out_dfreq #(
  parameter int DATA_BIT = 32,
  parameter int CNT_W    = 8,
  parameter int RPT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_out_dfreq_if.slave bus
);
  localparam int LEN_W = $clog2(DATA_BIT + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_BIT);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IM_LOW    = 2'b00;
  localparam logic [1:0] IM_HIGH   = 2'b01;
  localparam logic [1:0] IM_KEEP   = 2'b10;
  localparam logic [1:0] IM_REPEAT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // captured frame; data/fsel already in emission order (bit 0 goes out next)
  typedef struct packed {
    logic [DATA_BIT-1:0] data;
    logic [DATA_BIT-1:0] fsel;
    logic [LEN_W-1:0]    len;
    logic [CNT_W-1:0]    ph;
    logic [CNT_W-1:0]    pl;
  } frame_t;

  state_t           state, state_nxt;
  frame_t           fr, ld;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] bit_idx;
  logic             data_q, bit_tick_q;
  logic             bit_end, last_bit, rpt_go, load, idle_val;
  logic [CNT_W-1:0] cur_p;

  function automatic logic [DATA_BIT-1:0] rev(input logic [DATA_BIT-1:0] d);
    logic [DATA_BIT-1:0] r;
    for (int k = 0; k < DATA_BIT; k++) r[k] = d[DATA_BIT-1-k];
    return r;
  endfunction

  // live frame image from the inputs, normalised (len 0/oversize -> max, period 0 -> 1)
  always_comb begin
    ld.data = bus.i_msb_first ? rev(bus.i_data)     : bus.i_data;
    ld.fsel = bus.i_msb_first ? rev(bus.i_freq_sel) : bus.i_freq_sel;
    ld.len  = (bus.i_bit_len == '0 || bus.i_bit_len > LEN_MAX) ? LEN_MAX : bus.i_bit_len;
    ld.ph   = (bus.i_period_h == '0) ? CNT_ONE : bus.i_period_h;
    ld.pl   = (bus.i_period_l == '0) ? CNT_ONE : bus.i_period_l;
  end

  // bit timing and idle-level decode
  always_comb begin
    cur_p    = fr.fsel[0] ? fr.ph : fr.pl;
    bit_end  = (state == S_SHIFT) && bus.i_tick && (cnt == cur_p - CNT_ONE);
    last_bit = (bit_idx == fr.len - LEN_ONE);
    unique case (bus.i_idle_mode)
      IM_LOW:  idle_val = 1'b0;
      IM_HIGH: idle_val = 1'b1;
      IM_KEEP: idle_val = data_q;
      default: idle_val = 1'b0;
    endcase
  end

`ifdef SERIAL_OUT_RPT_CNT_EN
  logic [RPT_W-1:0] rpt_left;

  always_comb rpt_go = (bus.i_idle_mode == IM_REPEAT) && (rpt_left != '0);

  // remaining extra frames; captured only on the start from idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rpt_left <= '0;
    else if (load) rpt_left <= (state == S_IDLE) ? bus.i_repeat_cnt : rpt_left - RPT_W'(1);
  end
`else
  always_comb rpt_go = (bus.i_idle_mode == IM_REPEAT);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state; stop overrides everything
  always_comb begin
    state_nxt = state;
    if (bus.i_stop) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (bus.i_start) state_nxt = S_SHIFT;
        S_SHIFT: if (bit_end && last_bit) state_nxt = S_DONE;
        S_DONE:  state_nxt = rpt_go ? S_SHIFT : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    load            = (state_nxt == S_SHIFT) && (state != S_SHIFT);
    bus.o_busy      = (state != S_IDLE);
    bus.o_done_tick = (state == S_DONE);
    bus.o_data      = data_q;
    bus.o_bit_tick  = bit_tick_q;
  end

  // datapath: capture, tick counting, shifting and the registered serial pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr         <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      data_q     <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      bit_tick_q <= 1'b0;
      if (state_nxt == S_IDLE) begin
        data_q <= idle_val;
      end else if (load) begin
        fr         <= ld;
        cnt        <= '0;
        bit_idx    <= '0;
        data_q     <= ld.data[0];
        bit_tick_q <= 1'b1;
      end else if (state == S_SHIFT && bus.i_tick) begin
        if (bit_end) begin
          cnt <= '0;
          if (!last_bit) begin
            fr.data    <= fr.data >> 1;
            fr.fsel    <= fr.fsel >> 1;
            bit_idx    <= bit_idx + LEN_ONE;
            data_q     <= fr.data[1];
            bit_tick_q <= 1'b1;
          end
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_out_dfreq.sv
// Scoreboard bench for serial_out_dfreq: the driver pushes expected bit/done events,
// the monitor pops one per o_bit_tick/o_done_tick and checks value, kind and spacing,
// and checks o_data is held steady between events while busy.
module tb_serial_out_dfreq;
  localparam int DB = 32;
  localparam int CW = 8;
  localparam int RW = 8;
  localparam int LW = $clog2(DB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_out_dfreq_if #(.DATA_BIT(DB), .CNT_W(CW), .RPT_W(RW)) bus();
  serial_out_dfreq #(.DATA_BIT(DB), .CNT_W(CW), .RPT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { bit is_done; logic val; int dly; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, last_evt = 0;
  logic cur_val = 1'b0;
  int   tick_div = 1, tick_ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_ev(input bit d, input logic v, input int dl);
    exp_t e;
    e.is_done = d; e.val = v; e.dly = dl;
    exp_q.push_back(e);
  endtask

  // expected events for one frame; lim < 0 pushes whole frame, else only first lim bits
  task automatic push_frame(input logic [31:0] data, input logic [31:0] fsel, input bit msb,
                            input int len, input int ph, input int pl, input int div, input int lim);
    int n, prev, idx, p, dl;
    n = (len == 0 || len > DB) ? DB : len;
    prev = 0; idx = 0;
    for (int k = 0; k < n; k++) begin
      if (lim >= 0 && k >= lim) return;
      idx = msb ? DB - 1 - k : k;
      p = fsel[idx] ? ph : pl;
      if (p == 0) p = 1;
      dl = (k == 0) ? 1 : ((k == 1 && div > 1) ? -1 : prev * div);
      push_ev(1'b0, data[idx], dl);
      prev = p;
    end
    push_ev(1'b1, data[idx], (n == 1 && div > 1) ? -1 : prev * div);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input logic [31:0] data, input logic [31:0] fsel, input bit msb,
                             input int len, input int ph, input int pl);
    step();
    bus.i_data = data; bus.i_freq_sel = fsel; bus.i_msb_first = msb;
    bus.i_bit_len = LW'(len); bus.i_period_h = CW'(ph); bus.i_period_l = CW'(pl);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // prescaler model: i_tick every tick_div clocks
  initial begin
    bus.i_tick = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tick_div <= 1) bus.i_tick = 1'b1;
      else begin
        bus.i_tick = (tick_ph == 0);
        tick_ph = (tick_ph + 1) % tick_div;
      end
    end
  end

  // monitor: start marker, event scoreboard, hold check
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.o_busy && bus.i_start && !bus.i_stop) last_evt = cyc;
      if (bus.o_bit_tick || bus.o_done_tick) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, bus.o_done_tick, bus.o_bit_tick}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_done_kind", 32'(bus.o_done_tick), 32'(mon_e.is_done));
          chk("event_bit_kind", 32'(bus.o_bit_tick), 32'(!mon_e.is_done));
          chk("event_data", 32'(bus.o_data), 32'(mon_e.val));
          chk("event_busy", 32'(bus.o_busy), 32'd1);
          if (mon_e.dly >= 0) chk("event_spacing", 32'(cyc - last_evt), 32'(mon_e.dly));
        end
        last_evt = cyc;
        cur_val  = bus.o_data;
      end else if (bus.o_busy) begin
        chk("hold_data", 32'(bus.o_data), 32'(cur_val));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_idle_mode = 2'b00; bus.i_msb_first = 1'b0;
    bus.i_bit_len = '0; bus.i_data = '0; bus.i_freq_sel = '0;
    bus.i_period_h = '0; bus.i_period_l = '0;
`ifdef SERIAL_OUT_RPT_CNT_EN
    bus.i_repeat_cnt = '0;
`endif
    repeat (3) step();
    chk("reset_data", 32'(bus.o_data), 32'd0);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_bit_tick", 32'(bus.o_bit_tick), 32'd0);
    chk("reset_done_tick", 32'(bus.o_done_tick), 32'd0);
    rst_n = 1'b1;

    // idle levels
    bus.i_idle_mode = 2'b01; step(); step();
    chk("idle_high", 32'(bus.o_data), 32'd1);
    bus.i_idle_mode = 2'b00; step(); step();
    chk("idle_low", 32'(bus.o_data), 32'd0);

    // 1: LSB 0xA5, low nibble at h=2, high nibble at l=4
    push_ev(1'b0, 1'b1, 1); push_ev(1'b0, 1'b0, 2); push_ev(1'b0, 1'b1, 2); push_ev(1'b0, 1'b0, 2);
    push_ev(1'b0, 1'b0, 2); push_ev(1'b0, 1'b1, 4); push_ev(1'b0, 1'b0, 4); push_ev(1'b0, 1'b1, 4);
    push_ev(1'b1, 1'b1, 4);
    start_frame(32'h0000_00A5, 32'h0000_000F, 1'b0, 8, 2, 4);
    wait_drain(100);
    chk("t1_busy_after_done", 32'(bus.o_busy), 32'd0);
    chk("t1_idle_low_after_done", 32'(bus.o_data), 32'd0);

    // 2: full 32-bit MSB-first frame, period_h=0 treated as 1
    push_frame(32'h8000_0001, 32'hFFFF_0000, 1'b1, 0, 0, 1, 1, -1);
    start_frame(32'h8000_0001, 32'hFFFF_0000, 1'b1, 0, 0, 1);
    wait_drain(100);

    // 3: i_tick every 3rd clk, mid-frame start ignored, start+stop in idle
    tick_div = 3;
    push_frame(32'h0000_0006, 32'h0, 1'b0, 4, 1, 1, 3, -1);
    start_frame(32'h0000_0006, 32'h0, 1'b0, 4, 1, 1);
    step(); step();
    bus.i_data = 32'hFFFF_FFFF; bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    wait_drain(100);
    step();
    bus.i_start = 1'b1; bus.i_stop = 1'b1; step();
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    repeat (6) step();
    chk("t3_start_stop_idle_busy", 32'(bus.o_busy), 32'd0);
    tick_div = 1;

    // 4: REPEAT back-to-back frames, then stop mid-frame
    bus.i_idle_mode = 2'b11;
`ifdef SERIAL_OUT_RPT_CNT_EN
    bus.i_repeat_cnt = 8'd8;
`endif
    push_frame(32'h0000_0006, 32'h0, 1'b0, 4, 1, 2, 1, -1);
    push_frame(32'h0000_0006, 32'h0, 1'b0, 4, 1, 2, 1, -1);
    push_frame(32'h0000_0006, 32'h0, 1'b0, 4, 1, 2, 1, 2);
    start_frame(32'h0000_0006, 32'h0, 1'b0, 4, 1, 2);
    wait_drain(100);
    chk("t4_mid_bit_is_one", 32'(bus.o_data), 32'd1);
    bus.i_stop = 1'b1; step();
    chk("t4_stop_data", 32'(bus.o_data), 32'd0);
    chk("t4_stop_busy", 32'(bus.o_busy), 32'd0);
    chk("t4_stop_no_done", 32'(bus.o_done_tick), 32'd0);
    bus.i_stop = 1'b0;
    repeat (3) step();
    chk("t4_stays_idle", 32'(bus.o_busy), 32'd0);

`ifdef SERIAL_OUT_RPT_CNT_EN
    // 5: bounded REPEAT, 3 frames total
    bus.i_repeat_cnt = 8'd2;
    for (int f = 0; f < 3; f++) push_frame(32'h0000_0005, 32'h0000_0002, 1'b0, 3, 2, 1, 1, -1);
    start_frame(32'h0000_0005, 32'h0000_0002, 1'b0, 3, 2, 1);
    wait_drain(100);
    chk("t5_idle_busy", 32'(bus.o_busy), 32'd0);
    chk("t5_idle_data", 32'(bus.o_data), 32'd0);
    repeat (4) step();
    chk("t5_no_fourth_frame", 32'(bus.o_busy), 32'd0);
`endif

    // 6: KEEP holds last bit, reset mid-frame, clean restart
    bus.i_idle_mode = 2'b10;
    push_frame(32'h0000_0002, 32'h0, 1'b0, 2, 1, 1, 1, -1);
    start_frame(32'h0000_0002, 32'h0, 1'b0, 2, 1, 1);
    wait_drain(100);
    chk("t6_keep_1", 32'(bus.o_data), 32'd1);
    step(); step();
    chk("t6_keep_2", 32'(bus.o_data), 32'd1);
    push_frame(32'h0000_00F0, 32'h0, 1'b0, 8, 4, 4, 1, 3);
    start_frame(32'h0000_00F0, 32'h0, 1'b0, 8, 4, 4);
    wait_drain(100);
    chk("t6_pre_reset_busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_reset_data", 32'(bus.o_data), 32'd0);
    chk("t6_reset_busy", 32'(bus.o_busy), 32'd0);
    chk("t6_reset_bit_tick", 32'(bus.o_bit_tick), 32'd0);
    step(); step();
    rst_n = 1'b1;
    bus.i_idle_mode = 2'b00;
    push_frame(32'hA000_0000, 32'h0, 1'b1, 4, 1, 1, 1, -1);
    start_frame(32'hA000_0000, 32'h0, 1'b1, 4, 1, 1);
    wait_drain(100);
    chk("t6_restart_idle", 32'(bus.o_busy), 32'd0);

    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
